// File: rtl/iterative_shift_sequencer.sv
// Multi-cycle front-end for a 2-bit-control arithmetic right shifter: splits a wide
// shift amount into passes of at most 3 positions, feeding the shifter output back.
module iterative_shift_sequencer #(
    parameter int N  = 8,
    parameter int SW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic [SW-1:0] in_amount,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data,
    output logic [N-1:0]  sh_data,
    output logic [1:0]    sh_control,
    input  logic [N-1:0]  sh_result
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  acc_q, acc_d;
    logic [SW-1:0] rem_q, rem_d;
    logic [1:0]    step;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
        end
    end

    // Largest pass the shifter supports, or whatever is left over.
    always_comb begin
        step = (rem_q >= SW'(3)) ? 2'd3 : rem_q[1:0];
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        rem_d      = rem_q;
        sh_control = 2'd0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    acc_d   = in_data;
                    rem_d   = in_amount;
                    state_d = (in_amount != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                sh_control = step;
                acc_d      = sh_result;
                rem_d      = rem_q - SW'(step);
                if (rem_d == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = acc_q;
    assign sh_data   = acc_q;

endmodule

// File: tb/tb_iterative_shift_sequencer.sv
// Randomised self-checking bench for iterative_shift_sequencer against a
// plain-arithmetic reference (signed shift, ceil(a/3) passes).
module tb_iterative_shift_sequencer;

    localparam int N  = 8;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N-1:0]  in_data = '0;
    logic [SW-1:0] in_amount = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [N-1:0]  out_data;
    logic [N-1:0]  sh_data;
    logic [1:0]    sh_control;
    logic [N-1:0]  sh_result;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    // Behavioural stand-in for the downstream combinational shifter.
    assign sh_result = $signed(sh_data) >>> sh_control;

    iterative_shift_sequencer #(.N(N), .SW(SW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_amount  (in_amount),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .sh_data    (sh_data),
        .sh_control (sh_control),
        .sh_result  (sh_result)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request from IDLE and follow it to completion; out_ready is held
    // low for 'stall' cycles in DONE, optionally with a competing in_valid.
    task automatic run_txn(input logic [N-1:0] d, input int unsigned a,
                           input int unsigned stall, input bit compete);
        logic signed [N-1:0] sd;
        logic [N-1:0]        expv;
        int unsigned         passes;
        int unsigned         left;
        int unsigned         ctl;
        sd     = d;
        expv   = sd >>> a;
        passes = (a + 2) / 3;
        left   = a;

        check("accept_ready", {31'd0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        in_data   = d;
        in_amount = a[SW-1:0];
        out_ready = 1'b0;
        tick();

        for (int unsigned k = 0; k < passes; k++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = N'($urandom);
            in_amount = SW'($urandom);
            ctl = (left >= 3) ? 3 : left;
            check("shift_valid", {31'd0, out_valid}, 32'd0);
            check("shift_ready", {31'd0, in_ready}, 32'd0);
            check("shift_ctrl", {30'd0, sh_control}, ctl);
            left -= ctl;
            tick();
        end

        in_valid = 1'b0;
        check("done_valid", {31'd0, out_valid}, 32'd1);
        check("done_data", {24'd0, out_data}, {24'd0, expv});
        check("done_shdata", {24'd0, sh_data}, {24'd0, expv});
        check("done_ready", {31'd0, in_ready}, 32'd0);
        check("done_ctrl", {30'd0, sh_control}, 32'd0);

        for (int unsigned s = 0; s < stall; s++) begin
            in_valid  = compete;
            in_data   = N'($urandom);
            in_amount = SW'($urandom);
            tick();
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_data", {24'd0, out_data}, {24'd0, expv});
            check("stall_ready", {31'd0, in_ready}, 32'd0);
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("release_valid", {31'd0, out_valid}, 32'd0);
        check("release_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        // Reset and idle behaviour
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", {24'd0, out_data}, 32'd0);
        check("rst_shdata", {24'd0, sh_data}, 32'd0);
        check("rst_ctrl", {30'd0, sh_control}, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            in_data   = N'($urandom);
            in_amount = SW'($urandom);
            tick();
            check("idle_valid", {31'd0, out_valid}, 32'd0);
            check("idle_data", {24'd0, out_data}, 32'd0);
            check("idle_ready", {31'd0, in_ready}, 32'd1);
        end

        // Directed cases
        run_txn(8'hB4, 5, 0, 1'b0);
        run_txn(8'h70, 0, 0, 1'b0);
        run_txn(8'h70, 15, 0, 1'b0);
        run_txn(8'h80, 15, 0, 1'b0);
        run_txn(8'h80, 7, 0, 1'b0);
        run_txn(8'h9C, 2, 4, 1'b1);

        // Reset in the second SHIFT cycle of a 0x55 >>> 9 request
        in_valid  = 1'b1;
        in_data   = 8'h55;
        in_amount = 4'd9;
        tick();
        in_valid = 1'b0;
        check("mid_shift1", {31'd0, out_valid}, 32'd0);
        tick();
        check("mid_shift2_ctrl", {30'd0, sh_control}, 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_data", {24'd0, out_data}, 32'd0);
        check("mid_rst_ctrl", {30'd0, sh_control}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("mid_rst_quiet", {31'd0, out_valid}, 32'd0);
        end
        run_txn(8'h81, 1, 0, 1'b0);

        // Exhaustive data x amount sweep with random stalls and idle gaps
        for (int unsigned d = 0; d < 256; d++) begin
            for (int unsigned a = 0; a < 16; a++) begin
                int unsigned stall;
                stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
                run_txn(8'(d), a, stall, 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 7) == 0) begin
                    tick();
                    check("gap_ready", {31'd0, in_ready}, 32'd1);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/iterative_shift_sequencer.md
# iterative_shift_sequencer

Sequential front-end for the combinational 2-bit-control arithmetic right shifter. It accepts an N-bit signed word and a shift amount wider than the shifter supports (up to 2^SW−1), then drives the shifter for several cycles. Each cycle applies min(remaining, 3) bit positions and feeds the shifter output back as the next input. The final result is returned over a valid/ready handshake. It sits directly upstream of the shifter and also consumes the shifter's output.

## Interface
- N, default 8: data width; must match the shifter's N.
- SW, default 4: shift-amount width; legal amounts are 0..2^SW−1, and amounts ≥ N are legal.
- clk  input  1  single clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  block can accept a request.
- in_data  input  N  signed word to shift.
- in_amount  input  SW  total arithmetic right-shift amount.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_data  output  N  shifted result.
- sh_data  output  N  to shifter input_data.
- sh_control  output  2  to shifter control.
- sh_result  input  N  from shifter shifted_result; combinational, same cycle.

## Operation
- Registers:
  - state ∈ {IDLE, SHIFT, DONE}
  - acc[N-1:0]
  - rem[SW-1:0]
- Outputs are decoded from state:
  - in_ready = (state==IDLE)
  - out_valid = (state==DONE)
  - out_data = acc
  - sh_data = acc at all times
- IDLE:
  - On in_valid && in_ready: acc←in_data, rem←in_amount.
  - Next state is SHIFT if in_amount≠0, else DONE.
- SHIFT:
  - sh_control = (rem≥3) ? 3 : rem[1:0].
  - Each edge: acc←sh_result, rem←rem−sh_control.
  - When rem−sh_control==0, next state is DONE; otherwise remain in SHIFT.
  - Request inputs are ignored in this state.
- DONE:
  - out_valid=1. out_data is held stable until out_ready.
  - On out_valid && out_ready, next state is IDLE.
  - No same-cycle acceptance of a new request (in_ready=0 in DONE).
- sh_control = 0 in IDLE and DONE.
- Arithmetic rule:
  - Result must equal signed'(in_data) >>> in_amount for every data value and every legal amount.
  - Amounts ≥ N yield all sign bits: 0x00 or all-ones.
- No early termination: SHIFT runs the full ceil(a/3) cycles even when acc is already saturated, so latency is deterministic.
- Reset, including reset mid-SHIFT or mid-DONE:
  - At the next edge: state←IDLE, acc←0, rem←0.
  - An in-flight transaction is discarded and never produces out_valid.
  - A pending DONE result is dropped.

## Timing
- Reset values:
  - out_valid=0, out_data=0, sh_data=0, sh_control=0.
  - in_ready=1 from the first cycle after rst deasserts.
- Latency: request accepted in cycle 0 with amount a → out_valid first high in cycle ceil(a/3)+1.
  - a=0 → cycle 1.
  - a=3 → cycle 2.
  - a=15 → cycle 6.
- Throughput: one transaction per ceil(a/3)+2 cycles minimum, assuming out_ready is held high.
- in_ready and out_valid are never high in the same cycle.
- out_data and out_valid depend only on registers: no combinational path from any input.
- in_ready depends only on state.

## Test plan
- Reset and idle behaviour:
  - Hold rst for 3 cycles, then release → out_valid=0, out_data=0x00, sh_control=0, in_ready=1.
  - Outputs remain unchanged while in_valid=0.
- Multi-pass shift: in_data=0xB4, a=5.
  - sh_control=3 in cycle 1, then 2 in cycle 2.
  - out_valid in cycle 3 with out_data=0xFD.
- Boundary amounts:
  - 0x70, a=0 → 0x70 in cycle 1.
  - 0x70, a=15 → 0x00 in cycle 6.
  - 0x80, a=15 → 0xFF in cycle 6.
  - 0x80, a=7 → 0xFF in cycle 4.
- Backpressure: 0x9C, a=2 with out_ready=0 for 4 cycles.
  - out_data=0xE7 stays stable, out_valid stays 1, in_ready stays 0.
  - A competing in_valid is ignored.
  - out_ready=1 → IDLE next cycle.
- Reset mid-operation: 0x55, a=9, rst asserted in the 2nd SHIFT cycle.
  - Block is in IDLE next cycle; out_valid never rises.
  - Subsequent 0x81, a=1 → 0xC0 in cycle 2.
- Exhaustive sweep: all 256 data values × amounts 0..15 with random out_ready stalls.
  - Compare against signed'(in_data) >>> amount and check cycle-exact latency.
  - Expect zero errors.
